i2c_slave_regs: RTL and testbench

- I2C target block that sits directly downstream of the I2C master on the same SCL/SDA pair.
- Exposes a small byte-wide register file to the bus: write with pointer, read back with repeated START.
- Used both as the master's loopback bench partner and as the on-chip configuration target.
- Fully synchronous to the system clock; SCL/SDA are oversampled, never used as clocks.

---
 rtl/i2c_slave_regs.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_i2c_slave_regs.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regs.sv
`timescale 1ns/1ps
// i2c_slave_regs
// I2C target with a byte-wide register file.
// - A bus write sends the target address, then a pointer byte, then data bytes.
// - A bus read sends the pointer, a repeated START, then reads the data bytes.
// SCL and SDA are oversampled on i_sys_clk. They are never used as clocks.
// Optional build macro I2C_SLAVE_AUTOINC_EN: when it is defined, the pointer
// advances after each written byte and after each master-ACKed read byte.
// When it is undefined, the pointer holds its value.
module i2c_slave_regs #(
    parameter int         CLK_FREQ   = 25_000_000,
    parameter logic [6:0] SLAVE_ADDR = 7'h42,
    parameter int         NUM_REGS   = 16,
    parameter int         FILTER_LEN = 3,
    localparam int        PTR_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic             i_sys_clk,
    input  logic             i_sys_rstn,
    input  logic             i2c_scl,
    inout  wire              i2c_sda,
    input  logic [PTR_W-1:0] i_user_addr,
    output logic [7:0]       o_user_data,
    output logic             o_wr_strobe,
    output logic [PTR_W-1:0] o_wr_addr,
    output logic             o_busy
);

`ifdef I2C_SLAVE_AUTOINC_EN
    localparam logic [PTR_W-1:0] PTR_STEP = PTR_W'(1);
`else
    localparam logic [PTR_W-1:0] PTR_STEP = '0;
`endif

    // This branch never elaborates for a legal configuration. Its scope name
    // marks a bad build in the hierarchy.
    if (CLK_FREQ <= 0 || NUM_REGS < 2 || NUM_REGS > 256 || FILTER_LEN < 1) begin : g_bad_params
    end

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
        ST_WRITE, ST_WR_ACK, ST_READ, ST_MACK, ST_WAIT
    } state_t;

    state_t           state_reg, state_next;
    logic [3:0]       bit_cnt_reg, bit_cnt_next;
    logic [7:0]       shift_reg, shift_next;
    logic [PTR_W-1:0] ptr_reg, ptr_next;
    logic             rw_reg, rw_next;
    logic             ack_seen_reg, ack_seen_next;
    logic             sda_drive_reg, sda_drive_next;
    logic             busy_reg, busy_next;
    logic             wr_strobe_reg;
    logic [PTR_W-1:0] wr_addr_reg;
    logic             wr_en;
    logic [7:0]       wr_data;
    logic [7:0]       reg_file [NUM_REGS];

    // Input conditioning. Bit 0 carries SCL and bit 1 carries SDA.
    logic [1:0] pin_raw, line_filt, line_prev;
    assign pin_raw = {i2c_sda, i2c_scl};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_filt
            logic                  sync_reg;
            logic [FILTER_LEN-1:0] hist_reg;
            logic                  filt_reg;
            logic                  prev_reg;
            // The first sync stage is sync_reg. The second sync stage is hist_reg[0].
            // The filtered level changes only when the whole history agrees.
            // prev_reg is a delayed copy of the filtered level, used for edge detection.
            always_ff @(posedge i_sys_clk or negedge i_sys_rstn) begin
                if (!i_sys_rstn) begin
                    sync_reg <= 1'b1;
                    hist_reg <= '1;
                    filt_reg <= 1'b1;
                    prev_reg <= 1'b1;
                end else begin
                    sync_reg <= pin_raw[gi];
                    hist_reg <= FILTER_LEN'({hist_reg, sync_reg});
                    if (&hist_reg)
                        filt_reg <= 1'b1;
                    else if (~|hist_reg)
                        filt_reg <= 1'b0;
                    prev_reg <= filt_reg;
                end
            end
            assign line_filt[gi] = filt_reg;
            assign line_prev[gi] = prev_reg;
        end
    endgenerate

    logic scl_f, sda_f, scl_rise, scl_fall, sda_rise, sda_fall, start_det, stop_det;
    logic [7:0] shift_in;
    assign scl_f     = line_filt[0];
    assign sda_f     = line_filt[1];
    assign scl_rise  = line_filt[0] & ~line_prev[0];
    assign scl_fall  = ~line_filt[0] & line_prev[0];
    assign sda_rise  = line_filt[1] & ~line_prev[1];
    assign sda_fall  = ~line_filt[1] & line_prev[1];
    assign start_det = sda_fall & scl_f;
    assign stop_det  = sda_rise & scl_f;
    assign shift_in  = {shift_reg[6:0], sda_f};

    // Next-state logic. START and STOP take priority over bit events.
    // Each ACK phase works like this:
    //   - the first SCL fall starts driving 0;
    //   - the following SCL rise sets ack_seen;
    //   - the next SCL fall ends the ACK phase.
    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        ptr_next       = ptr_reg;
        rw_next        = rw_reg;
        ack_seen_next  = ack_seen_reg;
        sda_drive_next = sda_drive_reg;
        busy_next      = busy_reg;
        wr_en          = 1'b0;
        wr_data        = shift_in;
        if (start_det) begin
            state_next     = ST_ADDR;
            bit_cnt_next   = '0;
            ack_seen_next  = 1'b0;
            sda_drive_next = 1'b0;
        end else if (stop_det) begin
            state_next     = ST_IDLE;
            ack_seen_next  = 1'b0;
            sda_drive_next = 1'b0;
            busy_next      = 1'b0;
        end else begin
            case (state_reg)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_next   = shift_in;
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                        if (bit_cnt_reg == 4'd7) begin
                            bit_cnt_next  = '0;
                            rw_next       = sda_f;
                            ack_seen_next = 1'b0;
                            if (shift_reg[6:0] == SLAVE_ADDR) begin
                                state_next = ST_ADDR_ACK;
                            end else begin
                                state_next = ST_IDLE;
                                busy_next  = 1'b0;
                            end
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall && !ack_seen_reg) begin
                        sda_drive_next = 1'b1;
                        busy_next      = 1'b1;
                    end else if (scl_fall) begin
                        ack_seen_next = 1'b0;
                        bit_cnt_next  = '0;
                        if (rw_reg) begin
                            shift_next     = reg_file[ptr_reg];
                            sda_drive_next = ~reg_file[ptr_reg][7];
                            state_next     = ST_READ;
                        end else begin
                            sda_drive_next = 1'b0;
                            state_next     = ST_PTR;
                        end
                    end else if (scl_rise) begin
                        ack_seen_next = 1'b1;
                    end
                end
                ST_PTR, ST_WRITE: begin
                    if (scl_rise) begin
                        shift_next   = shift_in;
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                        if (bit_cnt_reg == 4'd7) begin
                            bit_cnt_next  = '0;
                            ack_seen_next = 1'b0;
                            if (state_reg == ST_PTR) begin
                                ptr_next   = shift_in[PTR_W-1:0];
                                state_next = ST_PTR_ACK;
                            end else begin
                                wr_en      = 1'b1;
                                state_next = ST_WR_ACK;
                            end
                        end
                    end
                end
                ST_PTR_ACK, ST_WR_ACK: begin
                    if (scl_fall && !ack_seen_reg) begin
                        sda_drive_next = 1'b1;
                    end else if (scl_fall) begin
                        ack_seen_next  = 1'b0;
                        bit_cnt_next   = '0;
                        sda_drive_next = 1'b0;
                        state_next     = ST_WRITE;
                        if (state_reg == ST_WR_ACK)
                            ptr_next = ptr_reg + PTR_STEP;
                    end else if (scl_rise) begin
                        ack_seen_next = 1'b1;
                    end
                end
                ST_READ: begin
                    // The master has sampled the current MSB by this rise, so shift it out.
                    if (scl_rise) begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                        shift_next   = {shift_reg[6:0], 1'b0};
                    end else if (scl_fall) begin
                        if (bit_cnt_reg == 4'd8) begin
                            bit_cnt_next   = '0;
                            ack_seen_next  = 1'b0;
                            sda_drive_next = 1'b0;
                            state_next     = ST_MACK;
                        end else begin
                            sda_drive_next = ~shift_reg[7];
                        end
                    end
                end
                ST_MACK: begin
                    if (scl_rise) begin
                        if (sda_f) begin
                            state_next = ST_WAIT;
                        end else begin
                            ptr_next      = ptr_reg + PTR_STEP;
                            ack_seen_next = 1'b1;
                        end
                    end else if (scl_fall && ack_seen_reg) begin
                        ack_seen_next  = 1'b0;
                        bit_cnt_next   = '0;
                        shift_next     = reg_file[ptr_reg];
                        sda_drive_next = ~reg_file[ptr_reg][7];
                        state_next     = ST_READ;
                    end
                end
                ST_WAIT: begin
                    sda_drive_next = 1'b0;
                end
                ST_IDLE: begin
                    sda_drive_next = 1'b0;
                end
                default: begin
                    state_next     = ST_IDLE;
                    sda_drive_next = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers. The async reset releases SDA at once.
    always_ff @(posedge i_sys_clk or negedge i_sys_rstn) begin
        if (!i_sys_rstn) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            ptr_reg       <= '0;
            rw_reg        <= 1'b0;
            ack_seen_reg  <= 1'b0;
            sda_drive_reg <= 1'b0;
            busy_reg      <= 1'b0;
            wr_strobe_reg <= 1'b0;
            wr_addr_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            ptr_reg       <= ptr_next;
            rw_reg        <= rw_next;
            ack_seen_reg  <= ack_seen_next;
            sda_drive_reg <= sda_drive_next;
            busy_reg      <= busy_next;
            wr_strobe_reg <= wr_en;
            if (wr_en)
                wr_addr_reg <= ptr_reg;
        end
    end

    // Register file write. The write lands in the same cycle the strobe rises.
    always_ff @(posedge i_sys_clk or negedge i_sys_rstn) begin
        if (!i_sys_rstn) begin
            for (int i = 0; i < NUM_REGS; i++)
                reg_file[i] <= '0;
        end else if (wr_en) begin
            reg_file[ptr_reg] <= wr_data;
        end
    end

    assign i2c_sda     = sda_drive_reg ? 1'b0 : 1'bz;
    assign o_user_data = reg_file[i_user_addr];
    assign o_wr_strobe = wr_strobe_reg;
    assign o_wr_addr   = wr_addr_reg;
    assign o_busy      = busy_reg;

endmodule

// File: tb/tb_i2c_slave_regs.sv
`timescale 1ns/1ps
// Testbench for i2c_slave_regs.
// A bit-banged bus master drives the design. The bench also holds a
// register-file reference model.
module tb_i2c_slave_regs;
    localparam int         NUM_REGS = 16;
    localparam int         PTR_W    = 4;
    localparam int         Q        = 16;
    localparam logic [6:0] DEV      = 7'h42;
`ifdef I2C_SLAVE_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic             clk       = 1'b0;
    logic             rstn      = 1'b0;
    logic             scl       = 1'b1;
    logic             m_sda_low = 1'b0;
    logic [PTR_W-1:0] user_addr = '0;
    logic [7:0]       user_data;
    logic             wr_strobe;
    logic [PTR_W-1:0] wr_addr;
    logic             busy;
    wire              sda_bus;

    pullup (sda_bus);
    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_regs [NUM_REGS];
    int         model_ptr = 0;
    logic [7:0] wbuf [4];
    int         exp_strobes[$];
    int         got_strobes[$];

    i2c_slave_regs #(
        .CLK_FREQ  (25_000_000),
        .SLAVE_ADDR(DEV),
        .NUM_REGS  (NUM_REGS),
        .FILTER_LEN(3)
    ) dut (
        .i_sys_clk  (clk),
        .i_sys_rstn (rstn),
        .i2c_scl    (scl),
        .i2c_sda    (sda_bus),
        .i_user_addr(user_addr),
        .o_user_data(user_data),
        .o_wr_strobe(wr_strobe),
        .o_wr_addr  (wr_addr),
        .o_busy     (busy)
    );

    always #20 clk = ~clk;

    always @(negedge clk) begin
        if (rstn && wr_strobe)
            got_strobes.push_back(int'(wr_addr));
    end

    initial begin
        #4ms;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_bit(input bit b, input bit glitch, output bit r);
        m_sda_low = !b;
        wait_q();
        scl = 1'b1;
        repeat (Q/2) @(negedge clk);
        if (glitch) begin
            m_sda_low = b;
            @(negedge clk);
            m_sda_low = !b;
        end
        r = sda_bus;
        repeat (Q/2) @(negedge clk);
        scl = 1'b0;
        wait_q();
    endtask

    task automatic start_cond();
        m_sda_low = 1'b0;
        wait_q();
        scl = 1'b1;
        wait_q();
        m_sda_low = 1'b1;
        wait_q();
        scl = 1'b0;
        wait_q();
    endtask

    task automatic stop_cond();
        m_sda_low = 1'b1;
        wait_q();
        scl = 1'b1;
        wait_q();
        m_sda_low = 1'b0;
        wait_q();
    endtask

    task automatic write_byte(input logic [7:0] d, input logic [7:0] gmask, output bit acked);
        bit r;
        for (int i = 7; i >= 0; i--)
            bus_bit(d[i], gmask[i], r);
        bus_bit(1'b1, 1'b0, r);
        acked = (r == 1'b0);
    endtask

    task automatic read_byte(input bit nack, output logic [7:0] d);
        bit r;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, 1'b0, r);
            d[i] = r;
        end
        bus_bit(nack, 1'b0, r);
    endtask

    task automatic check_strobes();
        check("strobe_count", got_strobes.size(), exp_strobes.size());
        if (got_strobes.size() == exp_strobes.size())
            foreach (exp_strobes[i])
                check("strobe_addr", got_strobes[i], exp_strobes[i]);
        got_strobes.delete();
        exp_strobes.delete();
    endtask

    task automatic check_regs();
        for (int a = 0; a < NUM_REGS; a++) begin
            user_addr = PTR_W'(a);
            #1;
            check("user_data", user_data, model_regs[a]);
        end
    endtask

    // Write transaction: address, pointer byte, then n data bytes from wbuf.
    task automatic do_write(input logic [6:0] a, input logic [7:0] p, input int n,
                            input logic [7:0] gmask, input bit do_stop);
        bit ack;
        bit match;
        match = (a == DEV);
        start_cond();
        write_byte({a, 1'b0}, 8'h00, ack);
        check("addr_ack", ack, match);
        check("busy_after_addr", busy, match);
        if (match) begin
            write_byte(p, 8'h00, ack);
            check("ptr_ack", ack, 1);
            model_ptr = p % NUM_REGS;
            for (int i = 0; i < n; i++) begin
                write_byte(wbuf[i], (i == 0) ? gmask : 8'h00, ack);
                check("data_ack", ack, 1);
                model_regs[model_ptr] = wbuf[i];
                exp_strobes.push_back(model_ptr);
                if (AUTOINC)
                    model_ptr = (model_ptr + 1) % NUM_REGS;
            end
            if (do_stop) begin
                stop_cond();
                check("busy_after_stop", busy, 0);
            end
        end
        check_strobes();
        $display("write addr=0x%02h ptr=0x%02h bytes=%0d", a, p, n);
    endtask

    // Read transaction, optionally preceded by a pointer write and a repeated
    // START. The master NACKs the last byte.
    task automatic do_read(input int n, input bit with_ptr, input logic [7:0] p);
        bit ack;
        bit r;
        logic [7:0] d;
        if (with_ptr) begin
            start_cond();
            write_byte({DEV, 1'b0}, 8'h00, ack);
            check("rd_addr_w_ack", ack, 1);
            write_byte(p, 8'h00, ack);
            check("rd_ptr_ack", ack, 1);
            model_ptr = p % NUM_REGS;
        end
        start_cond();
        write_byte({DEV, 1'b1}, 8'h00, ack);
        check("rd_addr_ack", ack, 1);
        for (int i = 0; i < n; i++) begin
            read_byte(i == n - 1, d);
            check("rd_data", d, model_regs[model_ptr]);
            if (AUTOINC && i < n - 1)
                model_ptr = (model_ptr + 1) % NUM_REGS;
        end
        for (int i = 0; i < 2; i++) begin
            bus_bit(1'b1, 1'b0, r);
            check("wait_released", r, 1);
        end
        stop_cond();
        check("busy_after_rd_stop", busy, 0);
        check("rd_no_strobe", got_strobes.size(), 0);
        got_strobes.delete();
        $display("read ptr_set=%0d ptr=0x%02h bytes=%0d", with_ptr, p, n);
    endtask

    initial begin
        bit   ack;
        int   n;
        for (int i = 0; i < NUM_REGS; i++)
            model_regs[i] = 8'h00;

        // Reset state
        repeat (5) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_strobe", wr_strobe, 0);
        check("rst_sda", sda_bus, 1);
        rstn = 1'b1;
        wait_q();
        check_regs();

        // Single write to register 3
        wbuf[0] = 8'hA5;
        do_write(DEV, 8'h03, 1, 8'h00, 1'b1);
        check_regs();

        // Three bytes starting at 0x0E (wraps with auto-increment)
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
        do_write(DEV, 8'h0E, 3, 8'h00, 1'b1);
        check_regs();

        // Preload reg[5], then read it back through a repeated START
        wbuf[0] = 8'h5A;
        do_write(DEV, 8'h05, 1, 8'h00, 1'b1);
        do_read(1, 1'b1, 8'h05);

        // Wrong address gets a NACK, then a START to the right address succeeds
        do_write(7'h43, 8'h00, 0, 8'h00, 1'b0);
        check_regs();
        wbuf[0] = 8'h77;
        do_write(DEV, 8'h09, 1, 8'h00, 1'b1);
        check_regs();

        // One-cycle SDA glitches while SCL is high must be filtered out
        wbuf[0] = 8'hC3; wbuf[1] = 8'h3C;
        do_write(DEV, 8'h02, 2, 8'hA4, 1'b1);
        check_regs();

        // Randomized traffic
        for (int t = 0; t < 6; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                n = $urandom_range(1, 3);
                for (int k = 0; k < n; k++)
                    wbuf[k] = 8'($urandom);
                do_write(DEV, 8'($urandom), n, 8'h00, 1'b1);
            end else begin
                do_read($urandom_range(1, 3), 1'($urandom_range(0, 1)), 8'($urandom));
            end
        end
        check_regs();

        // Reset during a read byte while the design drives SDA low
        wbuf[0] = 8'h12;
        do_write(DEV, 8'h07, 1, 8'h00, 1'b1);
        start_cond();
        write_byte({DEV, 1'b0}, 8'h00, ack);
        check("mr_addr_ack", ack, 1);
        write_byte(8'h07, 8'h00, ack);
        check("mr_ptr_ack", ack, 1);
        start_cond();
        write_byte({DEV, 1'b1}, 8'h00, ack);
        check("mr_rd_ack", ack, 1);
        check("mr_sda_driven", sda_bus, 0);
        rstn = 1'b0;
        #1;
        check("mr_sda_released", sda_bus, 1);
        $display("reset asserted mid read");
        m_sda_low = 1'b0;
        scl = 1'b1;
        repeat (4) @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < NUM_REGS; i++)
            model_regs[i] = 8'h00;
        model_ptr = 0;
        got_strobes.delete();
        wait_q();
        check("mr_busy", busy, 0);
        check_regs();
        do_read(2, 1'b0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
